lutk_frac_dffesr: RTL and testbench
===================================

LUTK_FRAC_DFFESR -- requirements
Module: lutk_frac_dffesr

Interface
REQ-001 SHALL have parameter K, default 4, LUT input count; legal range 4..6.
REQ-002 SHALL have parameter NoConfigBits, default 22, equal to 2**K+6; it is set manually per K and never derived arithmetically.
REQ-003 SHALL have port UserCLK  input  1  user clock; external, shared; all flops are posedge.
REQ-004 SHALL have port RESETn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port I  input  K  LUT inputs I[K-1:0].
REQ-006 SHALL have port Ci  input  1  carry-chain input.
REQ-007 SHALL have port SR  input  1  shared synchronous set/reset request.
REQ-008 SHALL have port EN  input  1  shared clock enable.
REQ-009 SHALL have port ConfigBits  input  NoConfigBits  global frame configuration.
REQ-010 SHALL have port O0  output  1  primary LUT/flop output.
REQ-011 SHALL have port O1  output  1  secondary (fractured half / duplicate register) output.
REQ-012 SHALL have port Co  output  1  carry-chain output.
REQ-013 SHALL decode ConfigBits as follows (N=2**K):
- INIT = [N-1:0]
- FF0 = [N]
- FF1 = [N+1]
- IOmux = [N+2]
- SET_NORESET0 = [N+3]
- SET_NORESET1 = [N+4]
- FRACTURE = [N+5]

Function
REQ-014 SHALL form effective input I0e = IOmux ? Ci : I[0]; LUT index = {I[K-1:1], I0e}.
REQ-015 Unfractured (FRACTURE=0): SHALL compute L0 = INIT[index]; SHALL set L1 = L0.
REQ-016 Fractured (FRACTURE=1): SHALL compute L0 = INIT[{0, index[K-2:0]}] (lower half) and L1 = INIT[{1, index[K-2:0]}] (upper half); I[K-1] is ignored by both halves.
REQ-017 SHALL contain two flops, F0 and F1; F0 captures L0 and F1 captures L1.
REQ-018 On each UserCLK rising edge with EN=1: if SR=1, F0<=SET_NORESET0 and F1<=SET_NORESET1; otherwise F0<=L0 and F1<=L1.
REQ-019 On each UserCLK rising edge with EN=0: flops hold; SR is ignored.
REQ-020 SHALL drive O0 = FF0 ? F0 : L0 and O1 = FF1 ? F1 : L1, combinationally.
REQ-021 SHALL compute Co = (Ci&I[1]) | (Ci&I[2]) | (I[1]&I[2]), independent of FRACTURE and IOmux.
REQ-022 Combinational paths (L0, L1, Co, unregistered O0/O1) SHALL have zero latency; registered paths SHALL have one UserCLK cycle of latency.
REQ-023 ConfigBits changes SHALL affect combinational outputs immediately; flops see new values only at the next enabled edge.

Reset
REQ-024 While RESETn=0, F0 and F1 SHALL be 0 asynchronously, overriding EN, SR and UserCLK.
REQ-025 During reset, a registered O0/O1 (FF=1) SHALL read 0; an unregistered O0/O1 SHALL follow the LUT.
REQ-026 After the RESETn rising edge, the first enabled UserCLK edge SHALL load per REQ-018.
REQ-027 Asserting RESETn mid-operation SHALL discard flop contents; no capture SHALL occur on an edge coincident with RESETn=0.
REQ-028 The SET_NORESET value SHALL apply only through synchronous SR, never through RESETn.

Configuration
REQ-029 Macro LUTK_FRACTURE_EN: when defined, FRACTURE mode SHALL be implemented per REQ-016.
REQ-030 When LUTK_FRACTURE_EN is undefined, the FRACTURE bit SHALL be ignored and treated as 0; NoConfigBits and the port list SHALL be unchanged, and the upper-half mux logic SHALL be absent.

Verification
REQ-031 K=4, INIT=16'h8000, FF0=0, I=4'hF -> O0=1; change I=4'hE -> O0=0 in the same cycle.
REQ-032 K=4, FF0=1, EN=1, SR=0, INIT=16'hFFFF -> O0=0 before the edge and 1 after one UserCLK edge; then EN=0 and INIT=0 -> O0 stays 1.
REQ-033 FF0=FF1=1, SET_NORESET0=1, SET_NORESET1=0, EN=1, SR=1 -> after the edge, O0=1 and O1=0; with EN=0 and SR=1, outputs hold.
REQ-034 Flops loaded with 1, RESETn pulled low between clock edges -> O0=O1=0 immediately; an edge during reset leaves them 0.
REQ-035 LUTK_FRACTURE_EN defined, K=4, FRACTURE=1, INIT=16'hFF00, I=4'b0xxx -> O0=0, O1=1; with the macro undefined, the same stimulus gives O0=O1=0.
REQ-036 IOmux=1, Ci=1, I[0]=0, INIT=16'h0002, I[3:1]=0 -> O0=1; with I[1]=1, Ci=1 -> Co=1; with I[1]=I[2]=0 -> Co=0.

Source files
------------

// File: rtl/lutk_frac_dffesr.sv
// K-input fracturable LUT with carry logic and two enable/sync-set-reset flops.
// Define LUTK_FRACTURE_EN to build the fractured (two K-1 input halves) mode.
module lutk_frac_dffesr #(
   parameter int K            = 4,
   parameter int NoConfigBits = 22
) (
   input  logic                    UserCLK,
   input  logic                    RESETn,
   input  logic [K-1:0]            I,
   input  logic                    Ci,
   input  logic                    SR,
   input  logic                    EN,
   input  logic [NoConfigBits-1:0] ConfigBits,
   output logic                    O0,
   output logic                    O1,
   output logic                    Co
);

   localparam int N = 2**K;

   logic [N-1:0] init;
   logic         ff0;
   logic         ff1;
   logic         io_mux;
   logic         set_noreset0;
   logic         set_noreset1;

   assign init         = ConfigBits[N-1:0];
   assign ff0          = ConfigBits[N];
   assign ff1          = ConfigBits[N+1];
   assign io_mux       = ConfigBits[N+2];
   assign set_noreset0 = ConfigBits[N+3];
   assign set_noreset1 = ConfigBits[N+4];

   logic         i0e;
   logic [K-1:0] lut_idx;
   logic         l0;
   logic         l1;
   logic         f0;
   logic         f1;

   // Carry-in can replace I[0] so an arithmetic chain feeds the LUT directly.
   assign i0e     = io_mux ? Ci : I[0];
   assign lut_idx = {I[K-1:1], i0e};

`ifdef LUTK_FRACTURE_EN
   logic fracture;
   assign fracture = ConfigBits[N+5];

   always_comb begin
      if (fracture) begin
         l0 = init[{1'b0, lut_idx[K-2:0]}];
         l1 = init[{1'b1, lut_idx[K-2:0]}];
      end else begin
         l0 = init[lut_idx];
         l1 = l0;
      end
   end
`else
   // Fracture bit stays in the frame layout but has no effect in this build.
   logic unused_fracture;
   assign unused_fracture = ConfigBits[N+5];

   assign l0 = init[lut_idx];
   assign l1 = l0;
`endif

   // NOTE: non-blocking assignments keep f0/f1 updates simultaneous at the edge;
   // blocking here would let simulation order leak into the captured values.
   always_ff @(posedge UserCLK or negedge RESETn) begin
      if (!RESETn) begin
         f0 <= 1'b0;
         f1 <= 1'b0;
      end else if (EN) begin
         if (SR) begin
            f0 <= set_noreset0;
            f1 <= set_noreset1;
         end else begin
            f0 <= l0;
            f1 <= l1;
         end
      end
   end

   assign O0 = ff0 ? f0 : l0;
   assign O1 = ff1 ? f1 : l1;
   assign Co = (Ci & I[1]) | (Ci & I[2]) | (I[1] & I[2]);

endmodule

// File: tb/tb_lutk_frac_dffesr.sv
// Scoreboard bench for lutk_frac_dffesr (K=4): stimulus queues expectations,
// a monitor process pops and compares them against {O0, O1, Co}.
module tb_lutk_frac_dffesr;

   localparam int K  = 4;
   localparam int NC = 22;

   logic          UserCLK;
   logic          RESETn;
   logic [K-1:0]  I;
   logic          Ci;
   logic          SR;
   logic          EN;
   logic [NC-1:0] ConfigBits;
   logic          O0;
   logic          O1;
   logic          Co;

   lutk_frac_dffesr #(.K(K), .NoConfigBits(NC)) dut (
      .UserCLK    (UserCLK),
      .RESETn     (RESETn),
      .I          (I),
      .Ci         (Ci),
      .SR         (SR),
      .EN         (EN),
      .ConfigBits (ConfigBits),
      .O0         (O0),
      .O1         (O1),
      .Co         (Co)
   );

   initial UserCLK = 1'b0;
   always #5 UserCLK = ~UserCLK;

   typedef struct {
      string name;
      logic  o0;
      logic  o1;
      logic  co;
   } exp_t;

   exp_t sb_q[$];
   int   req_cnt  = 0;
   int   done_cnt = 0;
   int   n_cmp    = 0;
   int   n_bad    = 0;

   // {FRACTURE, SNR1, SNR0, IOmux, FF1, FF0, INIT}
   function automatic logic [NC-1:0] mk_cfg(input logic [15:0] init, input logic ff0,
                                            input logic ff1, input logic iomux,
                                            input logic snr0, input logic snr1,
                                            input logic frac);
      return {frac, snr1, snr0, iomux, ff1, ff0, init};
   endfunction

   task automatic check(input string name, input logic o0, input logic o1, input logic co);
      exp_t e;
      e.name = name;
      e.o0   = o0;
      e.o1   = o1;
      e.co   = co;
      sb_q.push_back(e);
      req_cnt++;
      #1;
   endtask

   task automatic tick();
      @(posedge UserCLK);
      @(negedge UserCLK);
   endtask

   // Monitor: outputs are sampled while stimulus is parked mid-low-phase.
   initial begin
      exp_t e;
      forever begin
         wait (done_cnt < req_cnt);
         e = sb_q.pop_front();
         n_cmp++;
         if ({O0, O1, Co} !== {e.o0, e.o1, e.co}) begin
            n_bad++;
            $display("FAIL %s: got O0/O1/Co=%b%b%b want %b%b%b",
                     e.name, O0, O1, Co, e.o0, e.o1, e.co);
         end
         done_cnt++;
      end
   end

   initial begin
      logic frac_o1;
      RESETn     = 1'b0;
      I          = '0;
      Ci         = 1'b0;
      SR         = 1'b0;
      EN         = 1'b0;
      ConfigBits = mk_cfg(16'hFFFF, 1, 1, 0, 0, 0, 0);
      @(negedge UserCLK);
      #2;
      check("reset_registered", 1'b0, 1'b0, 1'b0);
      ConfigBits = mk_cfg(16'hFFFF, 0, 1, 0, 0, 0, 0);
      #1;
      check("reset_unreg_follows_lut", 1'b1, 1'b0, 1'b0);

      @(negedge UserCLK);
      RESETn = 1'b1;

      // Pure combinational LUT lookup.
      ConfigBits = mk_cfg(16'h8000, 0, 0, 0, 0, 0, 0);
      I = 4'hF;
      #1;
      check("lut_and4_hit", 1'b1, 1'b1, 1'b1);
      I = 4'hE;
      #1;
      check("lut_and4_miss", 1'b0, 1'b0, 1'b1);

      // Registered capture, then hold with EN=0.
      @(negedge UserCLK);
      I  = 4'h0;
      EN = 1'b1;
      ConfigBits = mk_cfg(16'hFFFF, 1, 1, 0, 0, 0, 0);
      #1;
      check("reg_before_edge", 1'b0, 1'b0, 1'b0);
      tick();
      check("reg_after_edge", 1'b1, 1'b1, 1'b0);
      EN = 1'b0;
      ConfigBits = mk_cfg(16'h0000, 1, 1, 0, 0, 0, 0);
      tick();
      check("reg_hold_en0", 1'b1, 1'b1, 1'b0);
      ConfigBits = mk_cfg(16'h0000, 1, 0, 0, 0, 0, 0);
      #1;
      check("mixed_reg_unreg", 1'b1, 1'b0, 1'b0);

      // Synchronous set/reset, then SR ignored while disabled.
      ConfigBits = mk_cfg(16'h0000, 1, 1, 0, 1, 0, 0);
      EN = 1'b1;
      SR = 1'b1;
      tick();
      check("sr_set0_reset1", 1'b1, 1'b0, 1'b0);
      EN = 1'b0;
      ConfigBits = mk_cfg(16'h0000, 1, 1, 0, 0, 1, 0);
      tick();
      check("sr_ignored_en0", 1'b1, 1'b0, 1'b0);
      EN = 1'b1;
      SR = 1'b0;
      ConfigBits = mk_cfg(16'hFFFF, 1, 1, 0, 0, 0, 0);
      tick();
      check("load_ones", 1'b1, 1'b1, 1'b0);

      // Asynchronous reset between edges, an edge during reset, then recovery.
      #2;
      RESETn = 1'b0;
      #1;
      check("async_reset_immediate", 1'b0, 1'b0, 1'b0);
      tick();
      check("edge_during_reset", 1'b0, 1'b0, 1'b0);
      RESETn = 1'b1;
      #1;
      check("reset_release_no_edge", 1'b0, 1'b0, 1'b0);
      tick();
      check("first_edge_after_reset", 1'b1, 1'b1, 1'b0);
      EN = 1'b0;

      // Fracture: lower half drives O0, upper half O1, I[3] ignored.
`ifdef LUTK_FRACTURE_EN
      frac_o1 = 1'b1;
`else
      frac_o1 = 1'b0;
`endif
      ConfigBits = mk_cfg(16'hFF00, 0, 0, 0, 0, 0, 1);
      I = 4'b0101;
      #1;
      check("fracture_lo_hi", 1'b0, frac_o1, 1'b0);
      I = 4'b1011;
      #1;
      check("fracture_i3_ignored", ~frac_o1, 1'b1, 1'b0);
      ConfigBits = mk_cfg(16'hFF00, 1, 1, 0, 0, 0, 1);
      I  = 4'b0101;
      EN = 1'b1;
      tick();
      check("fracture_registered", 1'b0, frac_o1, 1'b0);
      EN = 1'b0;

      // Carry input muxed into I0 and majority carry-out.
      ConfigBits = mk_cfg(16'h0002, 0, 0, 1, 0, 0, 0);
      Ci = 1'b1;
      I  = 4'b0000;
      #1;
      check("iomux_ci_as_i0", 1'b1, 1'b1, 1'b0);
      I = 4'b0010;
      #1;
      check("carry_ci_i1", 1'b0, 1'b0, 1'b1);
      ConfigBits = mk_cfg(16'h0002, 0, 0, 0, 0, 0, 0);
      I = 4'b0001;
      #1;
      check("iomux_off_i0", 1'b1, 1'b1, 1'b0);
      Ci = 1'b0;
      I  = 4'b0110;
      #1;
      check("carry_i1_i2", 1'b0, 1'b0, 1'b1);

      for (int t = 0; t < 100 && done_cnt != req_cnt; t++) #1;
      if (done_cnt != req_cnt) begin
         n_bad++;
         $display("FAIL monitor_drain: got %0d checked want %0d", done_cnt, req_cnt);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
